// File: rtl/ddc_snapshot_fifo.sv
// Snapshot FIFO: each capture strobe stores all channel words plus a timestamp in one of DEPTH slots.
// fill/rd_ready update on the push/pop edge and the readout registers one cycle later; define DDC_SNAPSHOT_SEQ_EN to add sequence numbers.
module ddc_snapshot_fifo #(
   parameter int NUM_CH = 32,
   parameter int DATA_W = 32,
   parameter int TIME_W = 26,
   parameter int DEPTH  = 4
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset,
   input  logic [NUM_CH*DATA_W-1:0]  ch_data,
   input  logic                      ch_valid,
   input  logic [TIME_W-1:0]         time_in,
   input  logic [$clog2(NUM_CH)-1:0] rd_sel,
   input  logic                      rd_ack,
   output logic [DATA_W-1:0]         rd_data,
   output logic [TIME_W-1:0]         rd_time,
   output logic [15:0]               rd_seq,
   output logic                      rd_ready,
   output logic [$clog2(DEPTH):0]    fill,
   output logic [15:0]               overflow_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(DEPTH);

   logic [NUM_CH*DATA_W-1:0] data_mem [DEPTH];
   logic [TIME_W-1:0]        time_mem [DEPTH];
   logic [PTR_W-1:0]         head;
   logic [PTR_W-1:0]         tail;
   logic [FILL_W-1:0]        fill_nxt;
   logic [NUM_CH*DATA_W-1:0] head_words;
   logic [DATA_W-1:0]        sel_word;
   logic                     is_empty;
   logic                     is_full;
   logic                     push;
   logic                     pop;
   logic                     drop;

   assign is_empty = (fill == '0);
   assign is_full  = (fill == FULL_CNT);
   assign pop      = rd_ack && !is_empty;
   // When FULL the pop frees the head slot, which is also the tail slot, so the push lands there.
   assign push     = ch_valid && (!is_full || pop);
   assign drop     = ch_valid && is_full && !rd_ack;

   always_comb begin
      fill_nxt = fill;
      if (push && !pop)
         fill_nxt = fill + 1'b1;
      else if (pop && !push)
         fill_nxt = fill - 1'b1;
   end

   assign head_words = data_mem[head];

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (int'(rd_sel) == k)
            sel_word = head_words[k*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk_clk) begin
      if (push && !reset_reset) begin
         data_mem[tail] <= ch_data;
         time_mem[tail] <= time_in;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         head         <= '0;
         tail         <= '0;
         fill         <= '0;
         rd_ready     <= 1'b0;
         rd_data      <= '0;
         rd_time      <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         fill     <= fill_nxt;
         rd_ready <= (fill_nxt != '0);
         if (drop && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;
         rd_data <= is_empty ? '0 : sel_word;
         rd_time <= is_empty ? '0 : time_mem[head];
      end
   end

`ifdef DDC_SNAPSHOT_SEQ_EN
   logic [15:0] seq_cnt;
   logic [15:0] seq_mem [DEPTH];

   always_ff @(posedge clk_clk) begin
      if (push && !reset_reset)
         seq_mem[tail] <= seq_cnt;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         seq_cnt <= '0;
         rd_seq  <= '0;
      end else begin
         if (push)
            seq_cnt <= seq_cnt + 16'd1;
         rd_seq <= is_empty ? '0 : seq_mem[head];
      end
   end
`else
   assign rd_seq = '0;
`endif

endmodule

// File: tb/tb_ddc_snapshot_fifo.sv
// Bench for ddc_snapshot_fifo: directed scenarios plus random traffic against a queue-based snapshot model.
module tb_ddc_snapshot_fifo;

   localparam int NUM_CH = 32;
   localparam int DATA_W = 32;
   localparam int TIME_W = 26;
   localparam int DEPTH  = 4;
   localparam int SEL_W  = 5;
   localparam int FILL_W = 3;
`ifdef DDC_SNAPSHOT_SEQ_EN
   localparam bit SEQ_EN = 1'b1;
`else
   localparam bit SEQ_EN = 1'b0;
`endif

   typedef struct packed {
      logic [NUM_CH*DATA_W-1:0] data;
      logic [TIME_W-1:0]        ts;
      logic [15:0]              seq;
   } snap_t;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_CH*DATA_W-1:0] ch_data = '0;
   logic                     ch_valid = 1'b0;
   logic [TIME_W-1:0]        time_in = '0;
   logic [SEL_W-1:0]         rd_sel = '0;
   logic                     rd_ack = 1'b0;
   logic [DATA_W-1:0]        rd_data;
   logic [TIME_W-1:0]        rd_time;
   logic [15:0]              rd_seq;
   logic                     rd_ready;
   logic [FILL_W-1:0]        fill;
   logic [15:0]              overflow_cnt;

   logic [47:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic [2:0]  s_sel = '0;
   logic        s_ack = 1'b0;
   logic [7:0]  s_rd_data;
   logic [7:0]  s_rd_time;
   logic [15:0] s_rd_seq;
   logic        s_rd_ready;
   logic [1:0]  s_fill;
   logic [15:0] s_ovf;

   int checks = 0;
   int failures = 0;

   snap_t             model_q[$];
   int                model_ovf = 0;
   logic [15:0]       model_seq = '0;
   logic [DATA_W-1:0] exp_data;
   logic [TIME_W-1:0] exp_time;
   logic [15:0]       exp_seq;
   logic [FILL_W-1:0] exp_fill;

   always #5 clk = ~clk;

   ddc_snapshot_fifo #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIME_W(TIME_W), .DEPTH(DEPTH)) dut (
      .clk_clk(clk), .reset_reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
      .time_in(time_in), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_data(rd_data),
      .rd_time(rd_time), .rd_seq(rd_seq), .rd_ready(rd_ready), .fill(fill),
      .overflow_cnt(overflow_cnt));

   ddc_snapshot_fifo #(.NUM_CH(6), .DATA_W(8), .TIME_W(8), .DEPTH(2)) u_small (
      .clk_clk(clk), .reset_reset(reset), .ch_data(s_data), .ch_valid(s_valid),
      .time_in(8'h5A), .rd_sel(s_sel), .rd_ack(s_ack), .rd_data(s_rd_data),
      .rd_time(s_rd_time), .rd_seq(s_rd_seq), .rd_ready(s_rd_ready), .fill(s_fill),
      .overflow_cnt(s_ovf));

   function automatic logic [DATA_W-1:0] word_of(input logic [NUM_CH*DATA_W-1:0] d, input int sel);
      if (sel >= NUM_CH) return '0;
      return d[sel*DATA_W +: DATA_W];
   endfunction

   // Advance one edge; readout expectations come from the state before the edge.
   task automatic step();
      snap_t s;
      bit    do_pop, do_push;
      if (model_q.size() == 0) begin
         exp_data = '0; exp_time = '0; exp_seq = '0;
      end else begin
         exp_data = word_of(model_q[0].data, int'(rd_sel));
         exp_time = model_q[0].ts;
         exp_seq  = SEQ_EN ? model_q[0].seq : 16'h0;
      end
      if (reset) begin
         model_q.delete();
         model_ovf = 0; model_seq = '0;
         exp_data = '0; exp_time = '0; exp_seq = '0;
      end else begin
         do_pop  = rd_ack && model_q.size() > 0;
         do_push = ch_valid && (model_q.size() < DEPTH || do_pop);
         if (do_pop) void'(model_q.pop_front());
         if (do_push) begin
            s.data = ch_data; s.ts = time_in; s.seq = model_seq;
            model_q.push_back(s);
            model_seq = model_seq + 16'd1;
         end else if (ch_valid && model_ovf < 65535) begin
            model_ovf++;
         end
      end
      exp_fill = FILL_W'(model_q.size());
      @(negedge clk);
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
      time_in = TIME_W'($urandom);
   endtask

   task automatic idle();
      ch_valid = 1'b0; rd_ack = 1'b0; s_valid = 1'b0; s_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle();
      step(); step();
      checks++; if (fill !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill); end
      checks++; if (rd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rd_ready); end
      checks++; if (overflow_cnt !== 16'h0) begin failures++; $display("FAIL reset_ovf got=%h exp=0", overflow_cnt); end
      checks++; if (rd_data !== '0 || rd_time !== '0 || rd_seq !== 16'h0) begin failures++; $display("FAIL reset_rd got=%h/%h/%h exp=0", rd_data, rd_time, rd_seq); end
      reset = 1'b0;
   endtask

   task automatic test_single_push();
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = 32'hA500_0000 + k;
      time_in = 26'h123; rd_sel = '0; ch_valid = 1'b1;
      step(); ch_valid = 1'b0;
      checks++; if (fill !== 3'd1 || rd_ready !== 1'b1) begin failures++; $display("FAIL push_fill got=%0d/%b exp=1/1", fill, rd_ready); end
      checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL push_latency got=%h exp=0", rd_data); end
      for (int i = 0; i < NUM_CH; i++) begin
         rd_sel = SEL_W'(i);
         step();
         checks++; if (rd_data !== 32'hA500_0000 + i || rd_data !== exp_data) begin failures++; $display("FAIL sweep_sel%0d got=%h exp=%h", i, rd_data, 32'hA500_0000 + i); end
      end
      checks++; if (rd_time !== 26'h123) begin failures++; $display("FAIL push_time got=%h exp=123", rd_time); end
      rd_ack = 1'b1; step(); rd_ack = 1'b0; step();
      checks++; if (fill !== 3'd0 || rd_data !== '0) begin failures++; $display("FAIL push_drain got=%0d/%h exp=0/0", fill, rd_data); end
   endtask

   task automatic test_overflow();
      logic [TIME_W-1:0] first_time;
      for (int i = 0; i < 7; i++) begin
         rand_inputs();
         if (i == 0) first_time = time_in;
         ch_valid = 1'b1; step();
      end
      ch_valid = 1'b0; rd_sel = SEL_W'($urandom); step();
      checks++; if (fill !== 3'd4) begin failures++; $display("FAIL ovf_fill got=%0d exp=4", fill); end
      checks++; if (overflow_cnt !== 16'd3) begin failures++; $display("FAIL ovf_cnt got=%0d exp=3", overflow_cnt); end
      checks++; if (rd_time !== first_time || rd_data !== exp_data) begin failures++; $display("FAIL ovf_head got=%h/%h exp=%h/%h", rd_time, rd_data, first_time, exp_data); end
      checks++; if (rd_seq !== 16'h0) begin failures++; $display("FAIL ovf_seq got=%h exp=0", rd_seq); end
   endtask

   task automatic test_full_push_pop();
      logic [TIME_W-1:0] new_time;
      rand_inputs(); new_time = time_in;
      ch_valid = 1'b1; rd_ack = 1'b1; step(); idle(); step();
      checks++; if (fill !== 3'd4 || overflow_cnt !== 16'd3) begin failures++; $display("FAIL fpp_fill got=%0d/%0d exp=4/3", fill, overflow_cnt); end
      for (int i = 0; i < 4; i++) begin
         rd_sel = SEL_W'($urandom); rd_ack = 1'b1; step();
         checks++; if (rd_data !== exp_data || rd_time !== exp_time || rd_seq !== exp_seq) begin failures++; $display("FAIL fpp_read%0d got=%h/%h/%h exp=%h/%h/%h", i, rd_data, rd_time, rd_seq, exp_data, exp_time, exp_seq); end
      end
      checks++; if (rd_time !== new_time) begin failures++; $display("FAIL fpp_fourth got=%h exp=%h", rd_time, new_time); end
      idle(); step();
      checks++; if (fill !== 3'd0 || rd_ready !== 1'b0) begin failures++; $display("FAIL fpp_empty got=%0d/%b exp=0/0", fill, rd_ready); end
   endtask

   task automatic test_empty_ack();
      rd_ack = 1'b1; step(); step(); rd_ack = 1'b0;
      checks++; if (fill !== 3'd0 || rd_ready !== 1'b0) begin failures++; $display("FAIL eack_fill got=%0d/%b exp=0/0", fill, rd_ready); end
      checks++; if (rd_data !== '0 || rd_time !== '0 || rd_seq !== 16'h0) begin failures++; $display("FAIL eack_rd got=%h/%h/%h exp=0", rd_data, rd_time, rd_seq); end
   endtask

   task automatic test_sel_range();
      for (int k = 0; k < 6; k++) s_data[k*8 +: 8] = 8'(8'h31 + k);
      s_valid = 1'b1; step(); s_valid = 1'b0;
      s_sel = 3'd7; step();
      checks++; if (s_rd_data !== 8'h00 || s_fill !== 2'd1) begin failures++; $display("FAIL sel7 got=%h/%0d exp=00/1", s_rd_data, s_fill); end
      s_sel = 3'd3; step();
      checks++; if (s_rd_data !== 8'h34 || s_rd_time !== 8'h5A) begin failures++; $display("FAIL sel3 got=%h/%h exp=34/5a", s_rd_data, s_rd_time); end
      s_sel = 3'd6; step();
      checks++; if (s_rd_data !== 8'h00) begin failures++; $display("FAIL sel6 got=%h exp=00", s_rd_data); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin rand_inputs(); ch_valid = 1'b1; step(); end
      reset = 1'b1; step(); reset = 1'b0;
      checks++; if (fill !== 3'd0 || rd_ready !== 1'b0 || overflow_cnt !== 16'h0) begin failures++; $display("FAIL rmid_state got=%0d/%b/%0d exp=0/0/0", fill, rd_ready, overflow_cnt); end
      rand_inputs(); step(); ch_valid = 1'b0;
      checks++; if (fill !== 3'd1) begin failures++; $display("FAIL rmid_push got=%0d exp=1", fill); end
      step();
      checks++; if (rd_seq !== 16'h0 || rd_data !== exp_data || rd_time !== exp_time) begin failures++; $display("FAIL rmid_head got=%h/%h exp=0/%h", rd_seq, rd_data, exp_data); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         ch_valid = ($urandom_range(0, 99) < 55);
         rd_ack   = ($urandom_range(0, 99) < 45);
         rd_sel   = SEL_W'($urandom);
         reset    = ($urandom_range(0, 299) == 0);
         step();
         checks++;
         if (fill !== exp_fill || rd_ready !== (exp_fill != 0) || overflow_cnt !== 16'(model_ovf) ||
             rd_data !== exp_data || rd_time !== exp_time || rd_seq !== exp_seq) begin
            failures++;
            $display("FAIL random_c%0d got=%0d/%b/%0d/%h/%h/%h exp=%0d/%0d/%h/%h/%h", i, fill, rd_ready, overflow_cnt,
                     rd_data, rd_time, rd_seq, exp_fill, model_ovf, exp_data, exp_time, exp_seq);
         end
      end
      reset = 1'b0; idle();
   endtask

   task automatic test_saturate();
      reset = 1'b1; step(); reset = 1'b0;
      ch_valid = 1'b1;
      for (int i = 0; i < 4 + 32'h10005; i++) step();
      ch_valid = 1'b0; step();
      checks++; if (overflow_cnt !== 16'hFFFF || model_ovf != 65535) begin failures++; $display("FAIL sat_ovf got=%h exp=ffff", overflow_cnt); end
      checks++; if (fill !== 3'd4) begin failures++; $display("FAIL sat_fill got=%0d exp=4", fill); end
   endtask

   task automatic test_seq_wrap();
`ifdef DDC_SNAPSHOT_SEQ_EN
      reset = 1'b1; step(); reset = 1'b0;
      ch_valid = 1'b1; step();
      rd_ack = 1'b1;
      for (int i = 0; i < 32'h10000; i++) step();
      idle(); step();
      checks++; if (rd_seq !== 16'h0 || exp_seq !== 16'h0 || fill !== 3'd1) begin failures++; $display("FAIL seq_wrap got=%h/%0d exp=0/1", rd_seq, fill); end
`endif
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_push();
      test_overflow();
      test_full_push_pop();
      test_empty_ack();
      test_sel_range();
      test_reset_mid();
      test_random();
      test_saturate();
      test_seq_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
